// File: rtl/dds_ftw_writer.sv
// dds_ftw_writer: serial master for the DDS frequency tuning word.
// It shifts {INSTR, ftw_in} out MSB first on SDIO/SCLK while CS_N is low,
// then optionally strobes IO_UPDATE before signalling done.
//
// Build option: define DDS_WRITER_AUTO_UPDATE_EN to include the UPDATE state
// and the IO_UPDATE pulse. Without it, IO_UPDATE is tied low and the frame
// ends straight after the final SCLK low phase. In that case a separate
// trigger path applies the word.
//
// Handshake: start is a single-cycle request. It is honoured only while busy=0.
// A start seen while busy=1 is dropped and not queued. done pulses for one
// cycle, with busy still high, when a transfer finishes.
//
// The FSM state is visible as the 'state' signal, which is a typed enum.
// All outputs come straight from flops. The flops are loaded from the
// next-state view, so each output lines up with the state it belongs to.
module dds_ftw_writer #(
    parameter int unsigned CLK_DIV = 5,
    parameter logic [7:0]  INSTR   = 8'h03
) (
    input  logic        fifty_MHz_int,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ftw_in,
    output logic        busy,
    output logic        done,
    output logic        SCLK,
    output logic        SDIO,
    output logic        CS_N,
    output logic        IO_UPDATE
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_SCLK_HI = 3'd2,
        S_SCLK_LO = 3'd3,
        S_UPDATE  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [5:0] NUM_BITS = 6'd40;

    state_t      state;
    state_t      state_next;
    logic [7:0]  div_cnt;
    logic [7:0]  div_cnt_next;
    logic [5:0]  bit_cnt;
    logic [5:0]  bit_cnt_next;
    logic [39:0] shreg;
    logic [39:0] shreg_next;
    logic        phase_end;

    logic        sclk_d;
    logic        sdio_d;
    logic        cs_n_d;
    logic        busy_d;
    logic        done_d;
    logic        io_update_d;

    // The current SCLK phase has run its full CLK_DIV cycles.
    assign phase_end = (div_cnt == 8'd0);

    // State register together with the divide counter, bit counter and shift register.
    always_ff @(posedge fifty_MHz_int) begin
        if (reset) begin
            state   <= S_IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= 6'd0;
            shreg   <= 40'd0;
        end else begin
            state   <= state_next;
            div_cnt <= div_cnt_next;
            bit_cnt <= bit_cnt_next;
            shreg   <= shreg_next;
        end
    end

    // Next-state and datapath updates. The divide counter reloads at every phase boundary.
    always_comb begin
        state_next   = state;
        div_cnt_next = phase_end ? DIV_LOAD : (div_cnt - 8'd1);
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        case (state)
            S_IDLE: begin
                div_cnt_next = DIV_LOAD;
                if (start) begin
                    state_next   = S_SETUP;
                    shreg_next   = {INSTR, ftw_in};
                    bit_cnt_next = 6'd0;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    state_next = S_SCLK_HI;
                end
            end
            S_SCLK_HI: begin
                // Leaving a high phase counts one bit and presents the next one.
                if (phase_end) begin
                    state_next   = S_SCLK_LO;
                    bit_cnt_next = bit_cnt + 6'd1;
                    shreg_next   = {shreg[38:0], 1'b0};
                end
            end
            S_SCLK_LO: begin
                if (phase_end) begin
                    if (bit_cnt == NUM_BITS) begin
`ifdef DDS_WRITER_AUTO_UPDATE_EN
                        state_next = S_UPDATE;
`else
                        state_next = S_DONE;
`endif
                    end else begin
                        state_next = S_SCLK_HI;
                    end
                end
            end
            S_UPDATE: begin
                if (phase_end) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                div_cnt_next = DIV_LOAD;
                state_next   = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state. After the 40th bit, SDIO is held at 0 during the hold phase.
    always_comb begin
        sclk_d      = (state_next == S_SCLK_HI);
        cs_n_d      = !(state_next inside {S_SETUP, S_SCLK_HI, S_SCLK_LO});
        sdio_d      = 1'b0;
        if (!cs_n_d && (bit_cnt_next != NUM_BITS)) begin
            sdio_d = shreg_next[39];
        end
        busy_d      = (state_next != S_IDLE);
        done_d      = (state_next == S_DONE);
        io_update_d = (state_next == S_UPDATE);
    end

    // Output flops. Reset puts the serial port in its idle condition.
    always_ff @(posedge fifty_MHz_int) begin
        if (reset) begin
            SCLK <= 1'b0;
            SDIO <= 1'b0;
            CS_N <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            SCLK <= sclk_d;
            SDIO <= sdio_d;
            CS_N <= cs_n_d;
            busy <= busy_d;
            done <= done_d;
        end
    end

`ifdef DDS_WRITER_AUTO_UPDATE_EN
    // IO_UPDATE strobe flop.
    always_ff @(posedge fifty_MHz_int) begin
        if (reset) begin
            IO_UPDATE <= 1'b0;
        end else begin
            IO_UPDATE <= io_update_d;
        end
    end
`else
    // The word is applied elsewhere. io_update_d stays low because UPDATE is never entered.
    assign IO_UPDATE = io_update_d & 1'b0;
`endif

endmodule

// File: tb/tb_dds_ftw_writer.sv
// tb_dds_ftw_writer: the bench runs two writers, one with CLK_DIV=5 and one
// with CLK_DIV=1, and one of them is observed at a time. A closed-form timing
// model gives every output on every cycle relative to the accept cycle T0.
// A scoreboard queue holds the frames expected to be decoded from SDIO on
// SCLK rising edges.
module tb_dds_ftw_writer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

`ifdef DDS_WRITER_AUTO_UPDATE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        reset;
  logic        start;
  logic [31:0] ftw_in;

  logic busy5, done5, sclk5, sdio5, cs_n5, iou5;
  logic busy1, done1, sclk1, sdio1, cs_n1, iou1;

  dds_ftw_writer #(.CLK_DIV(5), .INSTR(8'h03)) u_dut_div5 (
    .fifty_MHz_int(clk), .reset(reset), .start(start), .ftw_in(ftw_in),
    .busy(busy5), .done(done5), .SCLK(sclk5), .SDIO(sdio5), .CS_N(cs_n5),
    .IO_UPDATE(iou5)
  );

  dds_ftw_writer #(.CLK_DIV(1), .INSTR(8'h03)) u_dut_div1 (
    .fifty_MHz_int(clk), .reset(reset), .start(start), .ftw_in(ftw_in),
    .busy(busy1), .done(done1), .SCLK(sclk1), .SDIO(sdio1), .CS_N(cs_n1),
    .IO_UPDATE(iou1)
  );

  // Observed vector: {busy, done, sclk, sdio, cs_n, io_update}
  logic       sel;
  logic [5:0] outs;
  assign outs = sel ? {busy1, done1, sclk1, sdio1, cs_n1, iou1}
                    : {busy5, done5, sclk5, sdio5, cs_n5, iou5};

  localparam logic [5:0] IDLE_OUTS = 6'b000010;

  // ---------------- model state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          t0       = 0;
  int          d        = 5;
  bit          active   = 1'b0;
  logic [39:0] cur_frame = '0;
  logic [39:0] exp_q[$];
  logic [39:0] dec      = '0;
  int          rises    = 0;
  logic        prev_sclk = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int done_k(input int dv);
    return AUTO ? (82 * dv + 1) : (81 * dv + 1);
  endfunction

  // Expected outputs k cycles after the accept cycle, from the frame timing rules.
  function automatic logic [5:0] model_outs(input int k, input int dv, input logic [39:0] frame);
    int   p;
    int   n;
    logic in_frame, b, dn, sc, sd, cs, iu;
    in_frame = (k >= 1) && (k <= 81 * dv);
    p  = in_frame ? (k - 1) / dv : 0;
    n  = p / 2 + 1;
    b  = (k >= 1) && (k <= done_k(dv));
    dn = (k == done_k(dv));
    sc = in_frame && (p % 2 == 1);
    sd = (in_frame && p < 80) ? frame[40 - n] : 1'b0;
    cs = !in_frame;
    iu = AUTO && (k > 81 * dv) && (k <= 82 * dv);
    return {b, dn, sc, sd, cs, iu};
  endfunction

  function automatic bit model_idle();
    return !active || ((cyc - t0) > done_k(d));
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle's inputs just after a negedge, then sample at the next negedge.
  task automatic cycle(input logic st, input logic [31:0] w, input logic rst);
    logic [5:0]  e;
    logic [39:0] f;
    int          k;
    start  = st;
    ftw_in = w;
    reset  = rst;
    if (rst) begin
      active = 1'b0;
      exp_q.delete();
      dec   = '0;
      rises = 0;
    end else if (st && model_idle()) begin
      active    = 1'b1;
      t0        = cyc;
      cur_frame = {8'h03, w};
      exp_q.push_back({8'h03, w});
    end
    @(negedge clk);
    cyc++;
    k = cyc - t0;
    e = active ? model_outs(k, d, cur_frame) : IDLE_OUTS;
    check($sformatf("outs d=%0d k=%0d", d, k), outs, e);
    if (outs[3] && !prev_sclk) begin
      dec = {dec[38:0], outs[2]};
      rises++;
    end
    prev_sclk = outs[3];
    if (outs[4]) begin
      check("frame_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        f = exp_q.pop_front();
        check("frame_decoded", dec, f);
        check("sclk_rises", rises, 40);
      end
      dec   = '0;
      rises = 0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b0);
  endtask

  // Run until the model says the frame is over. If noisy is set, drop in occasional ignored starts.
  task automatic wait_idle(input bit noisy);
    while (!model_idle()) cycle(noisy && ($urandom_range(0, 7) == 0), $urandom, 1'b0);
  endtask

  task automatic run_until(input int k);
    while ((cyc - t0) < k) cycle(1'b0, $urandom, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sel    = 1'b0;
    d      = 5;
    start  = 1'b0;
    ftw_in = '0;
    reset  = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
    idle_cycles(2);

    // single write
    cycle(1'b1, 32'h12345678, 1'b0);
    wait_idle(1'b0);
    idle_cycles(2);

    // extremes
    cycle(1'b1, 32'h00000000, 1'b0);
    wait_idle(1'b0);
    cycle(1'b1, 32'hFFFFFFFF, 1'b0);
    wait_idle(1'b0);
    idle_cycles(1);

    // busy ignore, then a start exactly at T0+412
    cycle(1'b1, $urandom, 1'b0);
    run_until(100);
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    run_until(412);
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    wait_idle(1'b0);
    idle_cycles(2);

    // reset mid-frame at T0+200, then reset together with start
    cycle(1'b1, $urandom, 1'b0);
    run_until(200);
    cycle(1'b0, $urandom, 1'b1);
    idle_cycles(3);
    cycle(1'b1, $urandom, 1'b1);
    idle_cycles(3);
    cycle(1'b1, $urandom, 1'b0);
    wait_idle(1'b0);

    // random frames with random gaps and ignored starts
    for (int i = 0; i < 3; i++) begin
      idle_cycles($urandom_range(0, 3));
      cycle(1'b1, $urandom, 1'b0);
      wait_idle(1'b1);
    end

    // switch to the CLK_DIV=1 instance
    cycle(1'b0, 32'h0, 1'b1);
    sel       = 1'b1;
    d         = 1;
    prev_sclk = 1'b0;
    idle_cycles(2);
    cycle(1'b1, 32'hA5A5A5A5, 1'b0);
    wait_idle(1'b0);
    for (int i = 0; i < 5; i++) begin
      idle_cycles($urandom_range(0, 2));
      cycle(1'b1, $urandom, 1'b0);
      wait_idle(1'b1);
    end
    idle_cycles(3);

    check("frames_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
